// File: rtl/codificador_hamming_tx.sv
// Extended-Hamming (8,4) SECDED encoder with a UART-style serial transmitter.
// Accepts a nibble over a valid/ready handshake, holds the encoded word on
// palabra_8 and shifts it out LSB first between a start bit (0) and a stop
// bit (1), each bit held BIT_CICLOS clock cycles.
// Optional feature macro: INYECCION_ERROR_EN -- when defined, inyeccion_error
// is XORed into the word at acceptance; otherwise the port is ignored.
module codificador_hamming_tx #(
    parameter int unsigned BIT_CICLOS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dato_4,
    input  logic       dato_valido,
    input  logic [7:0] inyeccion_error,
    output logic       listo,
    output logic [7:0] palabra_8,
    output logic       tx_serial,
    output logic       fin
);

    localparam int unsigned CW = $clog2(BIT_CICLOS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CICLOS - 1);

    typedef enum logic [1:0] {StIdle, StInicio, StDatos, StParada} estado_e;

    estado_e       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    palabra_q, palabra_d;
    logic          listo_q, listo_d;
    logic          tx_q, tx_d;
    logic          fin_q, fin_d;

    logic       w0, w1, w2, w3;
    logic       p0, p1, p2, g0;
    logic [7:0] codigo;
    logic [7:0] mascara;
    logic       aceptar;
    logic       fin_bit;
    logic [2:0] bit_sig;

    // Combinational encoder: word = {g0,w3,w2,w1,p2,w0,p1,p0}
    always_comb begin
        {w3, w2, w1, w0} = dato_4;
        p0     = w0 ^ w1 ^ w3;
        p1     = w0 ^ w2 ^ w3;
        p2     = w1 ^ w2 ^ w3;
        g0     = w3 ^ w2 ^ w1 ^ p2 ^ w0 ^ p1 ^ p0;
        codigo = {g0, w3, w2, w1, p2, w0, p1, p0};
    end

`ifdef INYECCION_ERROR_EN
    assign mascara = inyeccion_error;
`else
    // Port kept for a uniform interface; its value is deliberately dropped.
    logic unused_inyeccion;
    assign unused_inyeccion = ^inyeccion_error;
    assign mascara          = 8'h00;
`endif

    assign aceptar = dato_valido & listo_q;
    assign fin_bit = (cnt_q == CNT_MAX);
    assign bit_sig = bit_q + 3'd1;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= StIdle;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            palabra_q <= 8'h00;
            listo_q   <= 1'b1;
            tx_q      <= 1'b1;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            palabra_q <= palabra_d;
            listo_q   <= listo_d;
            tx_q      <= tx_d;
            fin_q     <= fin_d;
        end
    end

    // Next-state logic: each non-idle state advances when its bit time expires
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            StIdle:   if (aceptar) estado_d = StInicio;
            StInicio: if (fin_bit) estado_d = StDatos;
            StDatos:  if (fin_bit && (bit_q == 3'd7)) estado_d = StParada;
            StParada: if (fin_bit) estado_d = StIdle;
            default:  estado_d = StIdle;
        endcase
    end

    // Output and datapath next values; outputs are registered to keep the line glitch-free
    always_comb begin
        cnt_d     = fin_bit ? '0 : cnt_q + CW'(1);
        bit_d     = bit_q;
        palabra_d = palabra_q;
        listo_d   = listo_q;
        tx_d      = tx_q;
        fin_d     = 1'b0;
        case (estado_q)
            StIdle: begin
                cnt_d = '0;
                if (aceptar) begin
                    palabra_d = codigo ^ mascara;
                    listo_d   = 1'b0;
                    tx_d      = 1'b0;
                end
            end
            StInicio: begin
                if (fin_bit) begin
                    bit_d = 3'd0;
                    tx_d  = palabra_q[0];
                end
            end
            StDatos: begin
                if (fin_bit) begin
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        bit_d = bit_sig;
                        tx_d  = palabra_q[bit_sig];
                    end
                end
            end
            StParada: begin
                if (fin_bit) begin
                    listo_d = 1'b1;
                    fin_d   = 1'b1;
                end
            end
            default: begin
                listo_d = 1'b1;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign listo     = listo_q;
    assign palabra_8 = palabra_q;
    assign tx_serial = tx_q;
    assign fin       = fin_q;

endmodule

// File: tb/tb_codificador_hamming_tx.sv
// Directed bench for codificador_hamming_tx: one instance with BIT_CICLOS=1
// and one with BIT_CICLOS=4. Expected words are hand-computed constants.
module tb_codificador_hamming_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance with one cycle per bit
    logic       rst1 = 1'b0, v1 = 1'b0;
    logic [3:0] d1 = 4'h0;
    logic [7:0] m1 = 8'h00;
    logic       listo1, tx1, fin1;
    logic [7:0] pal1;

    // Instance with four cycles per bit
    logic       rst4 = 1'b0, v4 = 1'b0;
    logic [3:0] d4 = 4'h0;
    logic [7:0] m4 = 8'h00;
    logic       listo4, tx4, fin4;
    logic [7:0] pal4;

    codificador_hamming_tx #(.BIT_CICLOS(1)) dut1 (
        .clk(clk), .rst(rst1), .dato_4(d1), .dato_valido(v1), .inyeccion_error(m1),
        .listo(listo1), .palabra_8(pal1), .tx_serial(tx1), .fin(fin1)
    );

    codificador_hamming_tx #(.BIT_CICLOS(4)) dut4 (
        .clk(clk), .rst(rst4), .dato_4(d4), .dato_valido(v4), .inyeccion_error(m4),
        .listo(listo4), .palabra_8(pal4), .tx_serial(tx4), .fin(fin4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one accept on dut1 (listo1 is expected high)
    task automatic send1(input logic [3:0] n, input logic [7:0] m);
        d1 = n; m1 = m; v1 = 1'b1;
        tick();
        v1 = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst4 = 1'b1;
        tick(); tick();
        rst1 = 1'b0; rst4 = 1'b0;
        tick();
        total++; if (listo1 !== 1'b1) begin bad++; $display("FAIL reset_listo1 got=%b exp=1", listo1); end
        total++; if (tx1 !== 1'b1) begin bad++; $display("FAIL reset_tx1 got=%b exp=1", tx1); end
        total++; if (pal1 !== 8'h00) begin bad++; $display("FAIL reset_pal1 got=%h exp=00", pal1); end
        total++; if (fin1 !== 1'b0) begin bad++; $display("FAIL reset_fin1 got=%b exp=0", fin1); end
        total++; if ({listo4, tx4, fin4, pal4} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            bad++; $display("FAIL reset_dut4 got=%b%b%b_%h exp=110_00", listo4, tx4, fin4, pal4);
        end
    endtask

    task automatic test_frame_bc1();
        logic exp_tx [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int bajos = 0;
        int fins  = 0;
        send1(4'b0110, 8'h00);
        total++; if (pal1 !== 8'h33) begin bad++; $display("FAIL frame_pal got=%h exp=33", pal1); end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (tx1 !== exp_tx[k]) begin
                bad++; $display("FAIL frame_tx[%0d] got=%b exp=%b", k, tx1, exp_tx[k]);
            end
            if (listo1 === 1'b0) bajos++;
            if (fin1 === 1'b1) fins++;
            tick();
        end
        total++; if (bajos != 10) begin bad++; $display("FAIL frame_listo_low got=%0d exp=10", bajos); end
        total++; if (fins != 0) begin bad++; $display("FAIL frame_fin_early got=%0d exp=0", fins); end
        total++; if (listo1 !== 1'b1) begin bad++; $display("FAIL frame_listo_end got=%b exp=1", listo1); end
        total++; if (fin1 !== 1'b1) begin bad++; $display("FAIL frame_fin_pulse got=%b exp=1", fin1); end
        tick();
        total++; if (fin1 !== 1'b0) begin bad++; $display("FAIL frame_fin_one got=%b exp=0", fin1); end
        total++; if (pal1 !== 8'h33) begin bad++; $display("FAIL frame_pal_hold got=%h exp=33", pal1); end
    endtask

    task automatic test_encode();
        logic [3:0] nib [3] = '{4'b0000, 4'b1111, 4'b1011};
        logic [7:0] exp [3] = '{8'h00, 8'hFF, 8'h55};
        logic [3:0] sind;
        int n;
        for (int i = 0; i < 3; i++) begin
            send1(nib[i], 8'h00);
            total++;
            if (pal1 !== exp[i]) begin
                bad++; $display("FAIL encode_%h got=%h exp=%h", nib[i], pal1, exp[i]);
            end
            sind = {^pal1,
                    pal1[3] ^ pal1[4] ^ pal1[5] ^ pal1[6],
                    pal1[1] ^ pal1[2] ^ pal1[5] ^ pal1[6],
                    pal1[0] ^ pal1[2] ^ pal1[4] ^ pal1[6]};
            total++;
            if (sind !== 4'b0000) begin
                bad++; $display("FAIL syndrome_%h got=%b exp=0000", nib[i], sind);
            end
            n = 0;
            while (listo1 !== 1'b1 && n < 30) begin tick(); n++; end
            total++; if (listo1 !== 1'b1) begin bad++; $display("FAIL encode_timeout got=%b exp=1", listo1); end
            tick();
        end
    endtask

    task automatic test_injection();
        logic [7:0] masks [2] = '{8'h04, 8'h84};
`ifdef INYECCION_ERROR_EN
        logic [7:0] exp [2] = '{8'h37, 8'hB7};
`else
        logic [7:0] exp [2] = '{8'h33, 8'h33};
`endif
        logic [7:0] rx;
        for (int i = 0; i < 2; i++) begin
            send1(4'b0110, masks[i]);
            m1 = 8'h00; d1 = 4'b0000;
            total++;
            if (pal1 !== exp[i]) begin
                bad++; $display("FAIL inject_%h got=%h exp=%h", masks[i], pal1, exp[i]);
            end
            tick();
            for (int b = 0; b < 8; b++) begin rx[b] = tx1; tick(); end
            total++;
            if (rx !== exp[i]) begin
                bad++; $display("FAIL inject_serial_%h got=%h exp=%h", masks[i], rx, exp[i]);
            end
            tick();
            total++; if (listo1 !== 1'b1) begin bad++; $display("FAIL inject_end got=%b exp=1", listo1); end
            tick();
        end
    endtask

    task automatic test_busy_bc4();
        int cyc;
        int estables;
        d4 = 4'b0110; m4 = 8'h00; v4 = 1'b1;
        tick();
        v4 = 1'b0;
        cyc = 0; estables = 1;
        while (listo4 !== 1'b1 && cyc < 60) begin
            if (cyc == 10) begin v4 = 1'b1; d4 = 4'b1011; m4 = 8'hFF; end
            if (cyc == 11) v4 = 1'b0;
            if (pal4 !== 8'h33) estables = 0;
            tick(); cyc++;
        end
        total++; if (cyc != 40) begin bad++; $display("FAIL busy_len got=%0d exp=40", cyc); end
        total++; if (estables != 1) begin bad++; $display("FAIL busy_pal_stable got=%0d exp=1", estables); end
        total++; if (fin4 !== 1'b1) begin bad++; $display("FAIL busy_fin got=%b exp=1", fin4); end
        m4 = 8'h00;
        tick();
        total++; if ({listo4, pal4} !== {1'b1, 8'h33}) begin
            bad++; $display("FAIL busy_no_queue got=%b_%h exp=1_33", listo4, pal4);
        end
        // Second frame, then a new request on the very cycle listo rises
        v4 = 1'b1; d4 = 4'b1011;
        tick();
        v4 = 1'b0;
        cyc = 0;
        while (listo4 !== 1'b1 && cyc < 60) begin tick(); cyc++; end
        total++; if (cyc != 40) begin bad++; $display("FAIL b2b_len got=%0d exp=40", cyc); end
        total++; if (tx4 !== 1'b1) begin bad++; $display("FAIL b2b_gap got=%b exp=1", tx4); end
        v4 = 1'b1; d4 = 4'b0110;
        tick();
        v4 = 1'b0;
        total++; if ({listo4, tx4, pal4} !== {1'b0, 1'b0, 8'h33}) begin
            bad++; $display("FAIL b2b_accept got=%b%b_%h exp=00_33", listo4, tx4, pal4);
        end
        cyc = 0;
        while (listo4 !== 1'b1 && cyc < 60) begin tick(); cyc++; end
        total++; if (cyc != 40) begin bad++; $display("FAIL b2b_len2 got=%0d exp=40", cyc); end
    endtask

    task automatic test_rst_mid_frame();
        logic [7:0] rx;
        logic       start_b, stop_b;
        send1(4'b0110, 8'h00);
        tick(); tick(); tick(); tick();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        total++; if ({tx1, listo1, fin1} !== 3'b110) begin
            bad++; $display("FAIL rst_mid got=%b%b%b exp=110", tx1, listo1, fin1);
        end
        total++; if (pal1 !== 8'h00) begin bad++; $display("FAIL rst_mid_pal got=%h exp=00", pal1); end
        tick();
        total++; if ({tx1, listo1, fin1} !== 3'b110) begin
            bad++; $display("FAIL rst_after got=%b%b%b exp=110", tx1, listo1, fin1);
        end
        send1(4'b1011, 8'h00);
        start_b = tx1;
        tick();
        for (int b = 0; b < 8; b++) begin rx[b] = tx1; tick(); end
        stop_b = tx1;
        tick();
        total++; if ({start_b, rx, stop_b} !== {1'b0, 8'h55, 1'b1}) begin
            bad++; $display("FAIL rst_new_frame got=%b_%h_%b exp=0_55_1", start_b, rx, stop_b);
        end
        total++; if ({listo1, fin1} !== 2'b11) begin
            bad++; $display("FAIL rst_new_end got=%b%b exp=11", listo1, fin1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame_bc1();
        test_encode();
        test_injection();
        test_busy_bc4();
        test_rst_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/codificador_hamming_tx.md
Name: codificador_hamming_tx

Overview:
Transmit-side counterpart of the SECDED syndrome detector. Accepts a 4-bit data nibble over a valid/ready handshake and encodes it into the 8-bit extended-Hamming word {g0,w3,w2,w1,p2,w0,p1,p0}. It holds the word on a parallel output and sends it as a UART-style serial frame, so a detector downstream can check it. An error mask can be injected so that single- and double-error cases can be built from known data.

Parameters:
BIT_CICLOS, 1, clock cycles each serial bit is held (legal range 1..65535); the counter is $clog2(BIT_CICLOS+1) bits wide.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
dato_4  input  4  data nibble {w3,w2,w1,w0}
dato_valido  input  1  data present; accepted only when listo=1
inyeccion_error  input  8  error mask XORed into the encoded word at acceptance
listo  output  1  block idle and able to accept
palabra_8  output  8  registered encoded (and injected) word
tx_serial  output  1  serial line; idles high
fin  output  1  one-cycle pulse when a frame completes

Behaviour:
- Encoding, combinational from dato_4:
  - p0 = w0^w1^w3
  - p1 = w0^w2^w3
  - p2 = w1^w2^w3
  - g0 = XOR of the 7 bits {w3,w2,w1,p2,w0,p1,p0}
  - word[7:0] = {g0,w3,w2,w1,p2,w0,p1,p0}
- Reset values (at the rst edge, regardless of state): state=IDLE, listo=1, palabra_8=8'h00, tx_serial=1, fin=0, bit and cycle counters=0.
- FSM states: IDLE, INICIO, DATOS, PARADA.
- IDLE: listo=1. An accept (dato_valido & listo at an edge) does the following on that edge:
  - loads palabra_8 <= word ^ mask (mask = inyeccion_error with the macro, else 0)
  - sets listo<=0, tx_serial<=0, enters INICIO
- INICIO: holds the start bit (0) for BIT_CICLOS cycles, then enters DATOS with tx_serial<=palabra_8[0].
- DATOS: sends palabra_8 bits 0..7, LSB first, each held BIT_CICLOS cycles. After bit 7 it enters PARADA with tx_serial<=1.
- PARADA: holds the stop bit (1) for BIT_CICLOS cycles, then returns to IDLE and drives listo<=1 and fin<=1. fin is high for exactly one cycle.
- Frame length is exactly 10*BIT_CICLOS cycles from the accept edge to the edge that raises listo.
- palabra_8 is stable for the whole frame and keeps its value in IDLE until the next accept.
- dato_valido while listo=0 is ignored; nothing is queued.
- Back-to-back frames: dato_valido may be asserted on the cycle listo rises. The accept occurs on the next edge, so tx_serial is high for at least 1 cycle between frames.
- rst asserted mid-frame aborts the frame. On the next edge the line returns high with listo=1 and no fin pulse.
- Changes on dato_4 and inyeccion_error after the accept edge have no effect on the frame in flight.

Optional Feature:
INYECCION_ERROR_EN
- Defined: inyeccion_error is XORed into palabra_8 at acceptance, and the serial frame carries the corrupted word.
- Undefined: the port remains in the port list but is ignored, and palabra_8 always equals the clean encoded word.

Test Plan:
1. rst=1 for 2 cycles, then release -> listo=1, tx_serial=1, palabra_8=8'h00, fin=0.
2. BIT_CICLOS=1, dato_4=4'b0110, mask=0, accept -> palabra_8=8'h33. tx_serial over the 10 cycles after the accept = 0,1,1,0,0,1,1,0,0,1. listo low for exactly 10 cycles; fin pulses once.
3. Encode checks: dato_4=4'b0000 -> 8'h00; 4'b1111 -> 8'hFF; 4'b1011 -> 8'h55. Each palabra_8 fed to the detector gives syndrome 4'b0000.
4. INYECCION_ERROR_EN defined: dato_4=4'b0110 with mask=8'h04 -> palabra_8=8'h37 (single error). With mask=8'h84 -> palabra_8=8'hB7 (double error). Without the macro, both cases give 8'h33.
5. BIT_CICLOS=4: accept, then pulse dato_valido=1 mid-frame with a different nibble -> the frame lasts exactly 40 cycles and palabra_8 is unchanged; the second nibble is sent only if dato_valido is still high after listo rises.
6. rst asserted at cycle 5 of a frame -> next edge: tx_serial=1, listo=1, fin stays 0. A new accept after rst releases sends a complete, correct frame.
